// File: rtl/uart_rx_core.sv
// UART receiver: synchronised line, 3-sample majority per bit, optional parity,
// one or two stop bits, and a one-entry valid/ready output register.
module uart_rx_core #(
    parameter int MSG_SIZE   = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                Tx,
    input  logic                sample_tick,
    input  logic                parity_en,
    input  logic                parity_type_even_odd,
    input  logic                two_stop,
    output logic [MSG_SIZE-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                parity_err,
    output logic                frame_err,
    output logic                break_det,
    output logic                overrun,
    output logic                busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(MSG_SIZE + 1);
    localparam logic [TW-1:0] T_C0  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_C1  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(MSG_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          sync_q, sync_d;
    logic [1:0]          fill_q, fill_d;
    logic                prev_q, prev_d;
    logic                arm_q, arm_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [1:0]          cap_q, cap_d;
    logic [MSG_SIZE-1:0] shift_q, shift_d;
    logic                par_q, par_d;
    logic                ferr_q, ferr_d;
    logic                pen_q, pen_d;
    logic                podd_q, podd_d;
    logic                two_q, two_d;
    logic [MSG_SIZE-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic                fe_q, fe_d;
    logic                brk_q, brk_d;
    logic                ovr_q, ovr_d;

    logic s, maj, mid, bend, done, fe_now, perr_new, brk_new, load;

    assign s = sync_q[1];
    assign maj = (cap_q[0] & cap_q[1]) | (cap_q[0] & s) | (cap_q[1] & s);
    assign mid = (tick_q == T_MID);
    assign bend = (tick_q == T_END);

    // fill_q marks when the synchroniser holds real line samples, so a
    // line low out of reset is never mistaken for a start edge.
    always_comb begin
        sync_d  = {sync_q[0], Tx};
        fill_d  = {fill_q[0], 1'b1};
        state_d = state_q;
        prev_d  = prev_q;
        arm_d   = arm_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        cap_d   = cap_q;
        shift_d = shift_q;
        par_d   = par_q;
        ferr_d  = ferr_q;
        pen_d   = pen_q;
        podd_d  = podd_q;
        two_d   = two_q;
        done    = 1'b0;
        fe_now  = ferr_q;
        if (sample_tick) begin
            prev_d = s;
            if (fill_q[1] && s) begin
                arm_d = 1'b1;
            end
            if (state_q != IDLE) begin
                tick_d = bend ? '0 : tick_q + 1'b1;
                if (tick_q == T_C0) cap_d[0] = s;
                if (tick_q == T_C1) cap_d[1] = s;
            end
            unique case (state_q)
                IDLE: begin
                    if (arm_q && prev_q && !s) begin
                        pen_d   = parity_en;
                        podd_d  = parity_type_even_odd;
                        two_d   = two_stop;
                        tick_d  = '0;
                        bit_d   = '0;
                        par_d   = 1'b0;
                        ferr_d  = 1'b0;
                        state_d = START;
                    end
                end
                START: begin
                    if (mid && maj) begin
                        state_d = IDLE;
                    end else if (bend) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (mid) begin
                        shift_d = {maj, shift_q[MSG_SIZE-1:1]};
                    end
                    if (bend) begin
                        if (bit_q == B_LAST) begin
                            bit_d   = '0;
                            state_d = pen_q ? PARITY : STOP1;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (mid) par_d = maj;
                    if (bend) state_d = STOP1;
                end
                STOP1: begin
                    if (mid) begin
                        fe_now = ferr_q | ~maj;
                        ferr_d = fe_now;
                        if (!two_q) begin
                            done    = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    if (bend && two_q) state_d = STOP2;
                end
                STOP2: begin
                    if (mid) begin
                        fe_now  = ferr_q | ~maj;
                        ferr_d  = fe_now;
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign perr_new = pen_q & (^shift_q ^ par_q ^ podd_q);
    assign brk_new = fe_now & (shift_q == '0) & (~pen_q | ~par_q);
    assign load = done & (~valid_q | rx_ready);

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        fe_d    = fe_q;
        brk_d   = brk_q;
        ovr_d   = done & ~load;
        if (load) begin
            data_d  = shift_q;
            perr_d  = perr_new;
            fe_d    = fe_now;
            brk_d   = brk_new;
            valid_d = 1'b1;
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            fill_q  <= 2'b00;
            prev_q  <= 1'b1;
            arm_q   <= 1'b0;
            tick_q  <= '0;
            bit_q   <= '0;
            cap_q   <= 2'b00;
            shift_q <= '0;
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
            pen_q   <= 1'b0;
            podd_q  <= 1'b0;
            two_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            fe_q    <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            prev_q  <= prev_d;
            arm_q   <= arm_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            cap_q   <= cap_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            ferr_q  <= ferr_d;
            pen_q   <= pen_d;
            podd_q  <= podd_d;
            two_q   <= two_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            fe_q    <= fe_d;
            brk_q   <= brk_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = fe_q;
    assign break_det  = brk_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: serial frames built bit by bit, results checked
// against a frame-level model of the expected word and flags.
module tb_uart_rx_core;

    localparam int MS = 8;
    localparam int OS = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          Tx = 1'b1;
    logic          sample_tick = 1'b1;
    logic          parity_en = 1'b0;
    logic          parity_type_even_odd = 1'b0;
    logic          two_stop = 1'b0;
    logic          rx_ready = 1'b1;
    logic [MS-1:0] rx_data;
    logic          rx_valid, parity_err, frame_err, break_det, overrun, busy;

    int n_chk = 0;
    int n_fail = 0;
    int tdiv = 1;
    int tph = 0;
    int ovr_cnt = 0;
    int vcyc = 0;
    logic [MS+2:0] got_q[$];

    uart_rx_core #(.MSG_SIZE(MS), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst_n(rst_n), .Tx(Tx), .sample_tick(sample_tick),
        .parity_en(parity_en), .parity_type_even_odd(parity_type_even_odd),
        .two_stop(two_stop), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
        .break_det(break_det), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) vcyc++;
            if (rx_valid && rx_ready)
                got_q.push_back({break_det, frame_err, parity_err, rx_data});
            if (overrun) ovr_cnt++;
        end
    end

    // Expected {break, frame, parity} flags from the frame as sent on the line.
    function automatic logic [2:0] model(input logic [MS-1:0] d, input logic pen,
                                         input logic odd, input logic p,
                                         input logic two, input logic st1,
                                         input logic st2);
        int ones;
        logic pc, pe, fe, brk;
        ones = 0;
        for (int i = 0; i < MS; i++) ones += int'(d[i]);
        pc = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
        pe = pen && (p != pc);
        fe = !st1 || (two && !st2);
        brk = fe && (d == '0) && (!pen || !p);
        return {brk, fe, pe};
    endfunction

    function automatic logic good_par(input logic [MS-1:0] d, input logic odd);
        int ones;
        ones = 0;
        for (int i = 0; i < MS; i++) ones += int'(d[i]);
        return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        sample_tick = (tph == 0);
        tph = (tph + 1) % tdiv;
    endtask

    task automatic hold(input logic v, input int nbits);
        repeat (nbits * OS * tdiv) begin
            step();
            Tx = v;
        end
    endtask

    task automatic send_frame(input logic [MS-1:0] d, input logic pen,
                              input logic odd, input logic p, input logic two,
                              input logic st1, input logic st2,
                              input logic scramble);
        parity_en = pen;
        parity_type_even_odd = odd;
        two_stop = two;
        hold(1'b0, 1);
        if (scramble) begin
            parity_en = 1'($urandom);
            parity_type_even_odd = 1'($urandom);
            two_stop = 1'($urandom);
        end
        for (int i = 0; i < MS; i++) hold(d[i], 1);
        if (pen) hold(p, 1);
        hold(st1, 1);
        if (two) hold(st2, 1);
    endtask

    task automatic wait_word(input int lim);
        for (int i = 0; i < lim && got_q.size() == 0; i++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_chk++;
        if (rx_data !== '0 || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data got %h/%b expected 00/0", rx_data, rx_valid);
        end
        n_chk++;
        if ({parity_err, frame_err, break_det, overrun} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b expected 0000",
                     {parity_err, frame_err, break_det, overrun});
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b expected 0", busy);
        end
        rst_n = 1'b1;
        hold(1'b1, 2);
    endtask

    task automatic test_8n1();
        logic [MS-1:0] d;
        rx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d = (k == 0) ? 8'hA5 : MS'($urandom);
            got_q.delete();
            vcyc = 0;
            send_frame(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            wait_word(4 * OS);
            hold(1'b1, 1);
            n_chk++;
            if (got_q.size() != 1) begin
                n_fail++;
                $display("FAIL 8n1_count got %0d expected 1", got_q.size());
            end else if (got_q[0] !== {3'b000, d}) begin
                n_fail++;
                $display("FAIL 8n1_word got %h expected %h", got_q[0], {3'b000, d});
            end
            n_chk++;
            if (vcyc != 1) begin
                n_fail++;
                $display("FAIL 8n1_valid_cycles got %0d expected 1", vcyc);
            end
        end
    endtask

    task automatic test_parity();
        logic [2:0] e;
        for (int p = 0; p < 2; p++) begin
            got_q.delete();
            send_frame(8'h03, 1'b1, 1'b0, 1'(p), 1'b0, 1'b1, 1'b1, 1'b0);
            wait_word(4 * OS);
            hold(1'b1, 1);
            e = model(8'h03, 1'b1, 1'b0, 1'(p), 1'b0, 1'b1, 1'b1);
            n_chk++;
            if (got_q.size() != 1 || got_q[0] !== {e, 8'h03}) begin
                n_fail++;
                $display("FAIL parity_p%0d got n=%0d %h expected %h", p,
                         got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, {e, 8'h03});
            end
        end
    endtask

    task automatic test_glitch();
        logic seen;
        got_q.delete();
        seen = 1'b0;
        repeat (5) begin
            step();
            Tx = 1'b0;
        end
        for (int i = 0; i < 2 * OS; i++) begin
            step();
            Tx = 1'b1;
            if (busy) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_seen got %b expected 1", seen);
        end
        n_chk++;
        if (busy !== 1'b0 || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_reject got busy=%b n=%0d expected 0/0", busy, got_q.size());
        end
    endtask

    task automatic test_overrun();
        got_q.delete();
        ovr_cnt = 0;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 2);
        n_chk++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            n_fail++;
            $display("FAIL overrun_hold got %b/%h expected 1/11", rx_valid, rx_data);
        end
        n_chk++;
        if (ovr_cnt != 1) begin
            n_fail++;
            $display("FAIL overrun_pulses got %0d expected 1", ovr_cnt);
        end
        rx_ready = 1'b1;
        repeat (3) step();
        n_chk++;
        if (got_q.size() != 1 || got_q[0] !== {3'b000, 8'h11} || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_drain got n=%0d v=%b expected 1 word 011 v=0",
                     got_q.size(), rx_valid);
        end
    endtask

    task automatic test_break();
        logic [2:0] e;
        got_q.delete();
        parity_en = 1'b1;
        parity_type_even_odd = 1'b0;
        two_stop = 1'b0;
        hold(1'b0, 12);
        e = model('0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (got_q.size() != 1 || got_q[0] !== {e, 8'h00}) begin
            n_fail++;
            $display("FAIL break_word got n=%0d %h expected %h", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : '0, {e, 8'h00});
        end
        hold(1'b1, 2);
        n_chk++;
        if (got_q.size() != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL break_rearm got n=%0d busy=%b expected 1/0", got_q.size(), busy);
        end
        got_q.delete();
        send_frame(8'h3C, 1'b1, 1'b0, good_par(8'h3C, 1'b0), 1'b0, 1'b1, 1'b1, 1'b0);
        wait_word(4 * OS);
        hold(1'b1, 1);
        n_chk++;
        if (got_q.size() != 1 || got_q[0] !== {3'b000, 8'h3C}) begin
            n_fail++;
            $display("FAIL break_recover got n=%0d expected word 03c", got_q.size());
        end
    endtask

    task automatic test_two_stop();
        logic [2:0] e;
        got_q.delete();
        send_frame(8'h5C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_word(4 * OS);
        hold(1'b1, 1);
        e = model(8'h5C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_chk++;
        if (got_q.size() != 1 || got_q[0] !== {e, 8'h5C} || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL two_stop got n=%0d v=%b expected %h v=0", got_q.size(),
                     rx_valid, {e, 8'h5C});
        end
    endtask

    task automatic test_reset_mid();
        logic [MS-1:0] d;
        d = 8'h5A;
        got_q.delete();
        ovr_cnt = 0;
        parity_en = 1'b0;
        two_stop = 1'b0;
        hold(1'b0, 1);
        for (int i = 0; i < 4; i++) hold(d[i], 1);
        repeat (OS / 2) begin
            step();
            Tx = d[4];
        end
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_busy_before got %b expected 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0 || rx_valid !== 1'b0 || overrun !== 1'b0 || rx_data !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs got b=%b v=%b o=%b d=%h expected 0/0/0/00",
                     busy, rx_valid, overrun, rx_data);
        end
        repeat (2) step();
        rst_n = 1'b1;
        hold(1'b1, 2);
        n_chk++;
        if (got_q.size() != 0 || ovr_cnt != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_quiet got n=%0d o=%0d b=%b expected 0/0/0",
                     got_q.size(), ovr_cnt, busy);
        end
        send_frame(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_word(4 * OS);
        hold(1'b1, 1);
        n_chk++;
        if (got_q.size() != 1 || got_q[0] !== {3'b000, d}) begin
            n_fail++;
            $display("FAIL midrst_next got n=%0d expected word 05a", got_q.size());
        end
    endtask

    task automatic test_tick_gating();
        logic [MS-1:0] d;
        logic [2:0] e;
        logic pen, odd, p;
        tdiv = 3;
        tph = 0;
        hold(1'b1, 1);
        for (int k = 0; k < 3; k++) begin
            d = MS'($urandom);
            pen = 1'(k);
            odd = 1'($urandom);
            p = good_par(d, odd) ^ 1'(k == 2);
            got_q.delete();
            send_frame(d, pen, odd, p, 1'b0, 1'b1, 1'b1, 1'b0);
            wait_word(4 * OS * tdiv);
            hold(1'b1, 1);
            e = model(d, pen, odd, p, 1'b0, 1'b1, 1'b1);
            n_chk++;
            if (got_q.size() != 1 || got_q[0] !== {e, d}) begin
                n_fail++;
                $display("FAIL tick_gating_%0d got n=%0d %h expected %h", k,
                         got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, {e, d});
            end
        end
        tdiv = 1;
        tph = 0;
    endtask

    task automatic test_random();
        logic [MS-1:0] d;
        logic [2:0] e;
        logic pen, odd, p, two, st1, st2;
        rx_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            d = ($urandom_range(0, 7) == 0) ? '0 : MS'($urandom);
            pen = 1'($urandom);
            odd = 1'($urandom);
            two = 1'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~good_par(d, odd) : good_par(d, odd);
            st1 = ($urandom_range(0, 4) != 0);
            st2 = ($urandom_range(0, 4) != 0);
            got_q.delete();
            send_frame(d, pen, odd, p, two, st1, st2, 1'b1);
            wait_word(4 * OS);
            hold(1'b1, 1 + int'($urandom_range(0, 1)));
            e = model(d, pen, odd, p, two, st1, st2);
            n_chk++;
            if (got_q.size() != 1 || got_q[0] !== {e, d}) begin
                n_fail++;
                $display("FAIL random_%0d got n=%0d %h expected %h (pen=%b odd=%b two=%b)",
                         k, got_q.size(), (got_q.size() > 0) ? got_q[0] : '0,
                         {e, d}, pen, odd, two);
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_overrun();
        test_break();
        test_two_stop();
        test_reset_mid();
        test_tick_gating();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised, self-contained UART receiver: oversampled start detection, 3-sample majority voting per bit, configurable data width, optional even/odd parity, and one or two stop bits. It reports parity, framing and break errors alongside each word, and delivers words through a one-entry valid/ready output register with overrun reporting. It sits between the asynchronous serial line and the receive-side consumer, replacing the fixed-width receive datapath and its external controller.

## Interface
- `MSG_SIZE`, default 8: data bits per frame; legal range 5..9.
- `OVERSAMPLE`, default 16: sample ticks per bit; even, ≥ 4.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `Tx` input 1: serial line; asynchronous to `clk`; idles high.
- `sample_tick` input 1: one-`clk` enable pulse at OVERSAMPLE × baud; tie high to oversample at the `clk` rate.
- `parity_en` input 1: 1 = frame carries a parity bit.
- `parity_type_even_odd` input 1: 0 = even parity, 1 = odd parity.
- `two_stop` input 1: 1 = two stop bits.
- `rx_data` output MSG_SIZE: received word; LSB is the first data bit on the line.
- `rx_valid` output 1: `rx_data` and its flags hold an unconsumed word.
- `rx_ready` input 1: consumer accepts the word when `rx_valid` and `rx_ready` are both high.
- `parity_err` output 1: parity mismatch on the held word; always 0 when `parity_en` was 0 for that frame.
- `frame_err` output 1: a stop bit of the held word was sampled low.
- `break_det` output 1: held word is a break condition.
- `overrun` output 1: one-cycle pulse when a completed frame is dropped.
- `busy` output 1: receiver state is not IDLE.

## Operation
- **Synchroniser.** `Tx` passes through 2 flip-flops that reset to 1. All line references below mean the synchronised value `s`.
- **Counters.**
  - Tick counter: width $clog2(OVERSAMPLE).
  - Bit counter: width $clog2(MSG_SIZE+1).
  - Both advance only on `sample_tick`.
- **Majority sampling.** Let M = OVERSAMPLE/2.
  - In each bit, `s` is captured at tick counts M-1, M and M+1.
  - The bit value is the majority of the three captures.
  - The bit period ends at count OVERSAMPLE-1; the tick counter then wraps to 0.
- **States:** IDLE, START, DATA, PARITY, STOP1, STOP2.
  - **IDLE.** On a tick where the previous tick's `s` was 1 and the current `s` is 0 (falling edge):
    - latch `parity_en`, `parity_type_even_odd` and `two_stop`;
    - clear the tick counter;
    - go to START.
    - A line held low from reset is not accepted until it has been high for at least one tick.
  - **START.**
    - Majority 1: false start; return to IDLE at count M+1.
    - Majority 0: go to DATA at the end of the bit.
  - **DATA.**
    - Each bit's majority shifts in at the MSB end; after MSG_SIZE bits the first bit received is in the LSB.
    - After bit MSG_SIZE-1: go to PARITY if the latched `parity_en` is 1, else STOP1.
  - **PARITY.** Captures bit p, then goes to STOP1.
  - **STOP1.**
    - Majority 0 sets the pending frame error.
    - `two_stop` = 0: the frame completes at count M+1, then return to IDLE.
    - `two_stop` = 1: go to STOP2 at the end of the bit.
  - **STOP2.** Same check as STOP1; the frame completes at count M+1, then return to IDLE.
- **Error flags for a completed frame.**
  - `parity_err` = (^data) ^ p ^ latched `parity_type_even_odd`, when parity is enabled.
  - `frame_err` = any stop bit sampled low.
  - `break_det` = `frame_err` & (data == 0) & (p == 0 or parity disabled).
- **Output register on frame completion.**
  - If `rx_valid` == 0, or `rx_valid` & `rx_ready` in the same cycle: load `rx_data` and the three flags, and set `rx_valid`.
  - Otherwise: drop the new frame, keep the held word unchanged, and pulse `overrun`.
- **Consume.** `rx_valid` & `rx_ready` with no simultaneous load clears `rx_valid`. `rx_data` and the flags hold their last values.
- **Configuration changes.** Changes to `parity_en`, `parity_type_even_odd` or `two_stop` during a frame have no effect until the next START.

## Timing
- **Reset values.** All outputs are 0. State is IDLE, counters are 0, and the synchroniser and previous-sample flops are 1.
- **Reset mid-frame.** Asserting `rst_n` mid-frame aborts the frame immediately, with no `rx_valid` and no `overrun`.
- **Start-detect latency.** 2 `clk` (synchroniser) plus alignment to the next tick.
- **Completion latency.** `rx_valid` rises 1 `clk` after the tick at count M+1 of the last stop bit.
- **Resynchronisation.** Completing at mid-stop lets a back-to-back frame be detected by its start edge without losing it.
- **Flag timing.** `overrun` is high for exactly 1 `clk`, in the same cycle the frame would have loaded.
- **Busy.** `busy` rises the cycle after start detect and falls when the state returns to IDLE.
- **Tick gating.** With `sample_tick` low, no counter, state or sampling changes occur. Handshake logic still operates every `clk`.

## Test plan
Unless stated, all scenarios use `MSG_SIZE`=8, `OVERSAMPLE`=16 and `sample_tick`=1.

1. 8N1 frame carrying 0xA5, `rx_ready`=1 → `rx_data`=0xA5, `rx_valid` high for 1 `clk`, all error flags 0.
2. 8E1 with `parity_en`=1 and `parity_type_even_odd`=0:
   - data 0x03 with parity bit 0 → `parity_err`=0;
   - data 0x03 with parity bit 1 → `parity_err`=1.
3. A low glitch of 5 ticks, then the line high → no `rx_valid`; `busy` returns low by count M+1.
4. Two frames 0x11 then 0x22 with `rx_ready`=0 → the held word stays 0x11, and `overrun` pulses once at completion of 0x22.
5. Line held low for 12 bit times with `parity_en`=1:
   - the frame completes with `rx_data`=0x00, `frame_err`=1, `break_det`=1;
   - no second frame is accepted until the line has been high for at least one tick.
6. Two cases, each reaching `rx_valid`=0:
   - `two_stop`=1 with the second stop bit low → `frame_err`=1;
   - `rst_n` pulsed during data bit 4 of a frame → outputs at 0 and state IDLE; the next clean frame 0x5A is received correctly.
